// File: rtl/axis_out_packer_pkg.sv
// Shared definitions for the AXI-Stream output packer.
//   - Element-size encodings carried on s_elem_bytes.
//   - Packer state enum.
//   - Helpers: output byte count, element-size legality and legalisation.
package axis_out_packer_pkg;

  localparam logic [2:0] EB_1 = 3'd1;
  localparam logic [2:0] EB_2 = 3'd2;
  localparam logic [2:0] EB_4 = 3'd4;

  typedef enum logic {
    StIdle,
    StPack
  } state_e;

  // Output word width in bytes (M_BYTES).
  function automatic int unsigned m_bytes(int unsigned m_width);
    return m_width / 8;
  endfunction

  function automatic logic eb_illegal(logic [2:0] eb);
    return !((eb == EB_1) || (eb == EB_2) || (eb == EB_4));
  endfunction

  // Illegal sizes fall back to 4-byte elements.
  function automatic logic [2:0] legal_eb(logic [2:0] eb);
    return eb_illegal(eb) ? EB_4 : eb;
  endfunction

endpackage

// File: rtl/out_elem_convert.sv
// Combinational element converter.
// Sign-extends each signed YBits input lane to 32 bits, clamping it to the
// signed range of the selected element size (1, 2 or 4 bytes).
// Ports:
//   data_i       Rows x YBits signed elements, element i at [YBits*(i+1)-1 : YBits*i]
//   elem_bytes_i element size, already legalised to 1/2/4
//   lanes_o      Rows x 32-bit converted lanes (only the low E bytes are meaningful)
//   sat_o        per-lane flag: lane was clamped
module out_elem_convert
  import axis_out_packer_pkg::*;
#(
  parameter int unsigned Rows  = 4,
  parameter int unsigned YBits = 24
) (
  input  logic [Rows*YBits-1:0] data_i,
  input  logic [2:0]            elem_bytes_i,
  output logic [Rows*32-1:0]    lanes_o,
  output logic [Rows-1:0]       sat_o
);

  logic signed [32:0] hi;
  logic signed [32:0] lo;
  logic signed [32:0] val;

  always_comb begin
    case (elem_bytes_i)
      EB_1: begin
        hi = 33'sh0_0000_007F;
        lo = 33'sh1_FFFF_FF80;
      end
      EB_2: begin
        hi = 33'sh0_0000_7FFF;
        lo = 33'sh1_FFFF_8000;
      end
      default: begin
        hi = 33'sh0_7FFF_FFFF;
        lo = 33'sh1_8000_0000;
      end
    endcase

    lanes_o = '0;
    sat_o   = '0;
    val     = '0;
    // When the element is at least YBits wide the input is always in range,
    // so the same compare degenerates to a plain sign extension.
    for (int unsigned i = 0; i < Rows; i++) begin
      val = {{(33 - YBits){data_i[YBits*i+YBits-1]}}, data_i[YBits*i +: YBits]};
      if (val > hi) begin
        lanes_o[32*i +: 32] = hi[31:0];
        sat_o[i]            = 1'b1;
      end else if (val < lo) begin
        lanes_o[32*i +: 32] = lo[31:0];
        sat_o[i]            = 1'b1;
      end else begin
        lanes_o[32*i +: 32] = val[31:0];
      end
    end
  end

endmodule

// File: rtl/axis_out_packer.sv
// AXI-Stream output packer.
// Converts ROWS signed Y_BITS results per input beat to a per-packet element
// size (1/2/4 bytes, saturating or sign-extending), packs whole beats
// little-endian into M_WIDTH-bit words and emits them with keep/last and a
// bytes-per-transfer sideband. Partial words are flushed on s_last.
// Ports:
//   aclk, areset            clock, synchronous active-high reset
//   s_valid/s_ready/s_data  input beat handshake and ROWS x Y_BITS payload
//   s_last                  last beat of packet
//   s_elem_bytes            element size, sampled on the first beat of a packet
//   m_valid/m_ready/m_data  output word handshake and payload
//   m_keep, m_last          byte enables, last word of packet
//   m_bytes_per_transfer    popcount of m_keep
//   sat_count               saturating count of clamped elements
//   cfg_err                 sticky illegal-element-size flag
module axis_out_packer
  import axis_out_packer_pkg::*;
#(
  parameter int unsigned ROWS    = 4,
  parameter int unsigned Y_BITS  = 24,
  parameter int unsigned M_WIDTH = 128,
  parameter int unsigned W_BPT   = 8
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [ROWS*Y_BITS-1:0] s_data,
  input  logic                   s_last,
  input  logic [2:0]             s_elem_bytes,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [M_WIDTH-1:0]     m_data,
  output logic [M_WIDTH/8-1:0]   m_keep,
  output logic                   m_last,
  output logic [W_BPT-1:0]       m_bytes_per_transfer,
  output logic [15:0]            sat_count,
  output logic                   cfg_err
);

  localparam int unsigned MBytes = m_bytes(M_WIDTH);
  localparam int unsigned MaxBpw = MBytes / ROWS;
  localparam int unsigned FillW  = $clog2(MaxBpw + 1);
  localparam int unsigned ByteW  = $clog2(MBytes + 1);
  localparam int unsigned BeatW  = ROWS * 32;
  localparam int unsigned SatW   = $clog2(ROWS + 1);

  state_e               state_q, state_d;
  logic [2:0]           elem_q, elem_d;
  logic [FillW-1:0]     fill_q, fill_d;
  logic [M_WIDTH-1:0]   acc_q, acc_d;
  logic                 m_valid_q, m_valid_d;
  logic [M_WIDTH-1:0]   m_data_q, m_data_d;
  logic [MBytes-1:0]    m_keep_q, m_keep_d;
  logic                 m_last_q, m_last_d;
  logic [W_BPT-1:0]     m_bpt_q, m_bpt_d;
  logic [15:0]          sat_q, sat_d;
  logic                 cfg_err_q, cfg_err_d;

  logic [2:0]           cur_e;
  logic [BeatW-1:0]     lanes;
  logic [ROWS-1:0]      sat_lane;
  logic [BeatW-1:0]     beat_packed;
  logic [M_WIDTH-1:0]   word_new;
  logic [MBytes-1:0]    keep_new;
  logic [ByteW-1:0]     beat_bytes;
  logic [ByteW-1:0]     offset_bytes;
  logic [ByteW-1:0]     fill_bytes;
  logic [FillW-1:0]     bpw;
  logic [FillW-1:0]     fill_inc;
  logic [SatW-1:0]      sat_add;
  logic [16:0]          sat_sum;
  logic                 accept;
  logic                 emit;

  assign s_ready = !m_valid_q || m_ready;
  assign accept  = s_valid && s_ready;

  // The first beat of a packet converts with its own s_elem_bytes, later
  // beats with the latched size.
  assign cur_e = (state_q == StIdle) ? legal_eb(s_elem_bytes) : elem_q;

  out_elem_convert #(
    .Rows  (ROWS),
    .YBits (Y_BITS)
  ) u_conv (
    .data_i       (s_data),
    .elem_bytes_i (cur_e),
    .lanes_o      (lanes),
    .sat_o        (sat_lane)
  );

  // Packing datapath: current beat compacted to E-byte lanes, then placed at
  // the current fill offset on top of the accumulator.
  always_comb begin
    case (cur_e)
      EB_1: begin
        beat_bytes = ByteW'(ROWS);
        bpw        = FillW'(MBytes / ROWS);
      end
      EB_2: begin
        beat_bytes = ByteW'(2 * ROWS);
        bpw        = FillW'(MBytes / (2 * ROWS));
      end
      default: begin
        beat_bytes = ByteW'(4 * ROWS);
        bpw        = FillW'(MBytes / (4 * ROWS));
      end
    endcase

    beat_packed = '0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      case (cur_e)
        EB_1:    beat_packed[8*i +: 8]   = lanes[32*i +: 8];
        EB_2:    beat_packed[16*i +: 16] = lanes[32*i +: 16];
        default: beat_packed[32*i +: 32] = lanes[32*i +: 32];
      endcase
    end

    fill_inc     = fill_q + 1'b1;
    offset_bytes = ByteW'(fill_q) * beat_bytes;
    fill_bytes   = ByteW'(fill_inc) * beat_bytes;
    word_new     = acc_q | (M_WIDTH'(beat_packed) << {offset_bytes, 3'b000});
    keep_new     = ~({MBytes{1'b1}} << fill_bytes);
    emit         = accept && ((fill_inc == bpw) || s_last);

    sat_add = '0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      sat_add = sat_add + SatW'(sat_lane[i]);
    end
    sat_sum = {1'b0, sat_q} + 17'(sat_add);
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    elem_d    = elem_q;
    fill_d    = fill_q;
    acc_d     = acc_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_last_d  = m_last_q;
    m_bpt_d   = m_bpt_q;
    sat_d     = sat_q;
    cfg_err_d = cfg_err_q;

    if (m_ready) begin
      m_valid_d = 1'b0;
    end

    if (accept) begin
      sat_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];

      if (state_q == StIdle) begin
        elem_d  = cur_e;
        state_d = StPack;
        if (eb_illegal(s_elem_bytes)) begin
          cfg_err_d = 1'b1;
        end
      end

      if (emit) begin
        // Emitting overrides any hand-off in the same cycle: no bubble.
        acc_d     = '0;
        fill_d    = '0;
        m_valid_d = 1'b1;
        m_data_d  = word_new;
        m_keep_d  = keep_new;
        m_last_d  = s_last;
        m_bpt_d   = W_BPT'(fill_bytes);
        if (s_last) begin
          state_d = StIdle;
        end
      end else begin
        acc_d  = word_new;
        fill_d = fill_inc;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= StIdle;
      elem_q    <= EB_4;
      fill_q    <= '0;
      acc_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
      m_bpt_q   <= '0;
      sat_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      elem_q    <= elem_d;
      fill_q    <= fill_d;
      acc_q     <= acc_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_last_q  <= m_last_d;
      m_bpt_q   <= m_bpt_d;
      sat_q     <= sat_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign m_valid              = m_valid_q;
  assign m_data               = m_data_q;
  assign m_keep               = m_keep_q;
  assign m_last               = m_last_q;
  assign m_bytes_per_transfer = m_bpt_q;
  assign sat_count            = sat_q;
  assign cfg_err              = cfg_err_q;

endmodule

// File: tb/tb_axis_out_packer.sv
module tb_axis_out_packer;

  logic         clk = 1'b0;
  logic         areset, s_valid, s_ready, s_last, m_valid, m_ready, m_last, cfg_err;
  logic [95:0]  s_data;
  logic [2:0]   s_elem_bytes;
  logic [127:0] m_data;
  logic [15:0]  m_keep;
  logic [7:0]   m_bpt;
  logic [15:0]  sat_count;

  axis_out_packer #(
    .ROWS    (4),
    .Y_BITS  (24),
    .M_WIDTH (128),
    .W_BPT   (8)
  ) dut (
    .aclk                 (clk),
    .areset               (areset),
    .s_valid              (s_valid),
    .s_ready              (s_ready),
    .s_data               (s_data),
    .s_last               (s_last),
    .s_elem_bytes         (s_elem_bytes),
    .m_valid              (m_valid),
    .m_ready              (m_ready),
    .m_data               (m_data),
    .m_keep               (m_keep),
    .m_last               (m_last),
    .m_bytes_per_transfer (m_bpt),
    .sat_count            (sat_count),
    .cfg_err              (cfg_err)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;
  int stall_err = 0;
  bit bp_en  = 0;
  bit gap_en = 0;

  logic [127:0] rx_data[$];
  logic [15:0]  rx_keep[$];
  logic         rx_last[$];
  logic [7:0]   rx_bpt[$];
  int           rx_cyc[$];
  int           acc_cyc[$];

  logic [127:0] exp_data[$];
  logic [15:0]  exp_keep[$];
  logic         exp_last[$];
  logic [7:0]   exp_bpt[$];
  int           exp_sat;

  int vals[8][4];

  logic         prev_stall = 0;
  logic [127:0] pd;
  logic [15:0]  pk;
  logic         pl;
  logic [7:0]   pb;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bp_en) begin
      #1;
      m_ready = 1'($urandom_range(0, 1));
    end
  end

  // Output monitor: collects handshaken words and flags changes while stalled.
  always @(negedge clk) begin
    if (areset) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (!m_valid || m_data !== pd || m_keep !== pk || m_last !== pl ||
                         m_bpt !== pb))
        stall_err <= stall_err + 1;
      prev_stall <= m_valid && !m_ready;
      pd <= m_data;
      pk <= m_keep;
      pl <= m_last;
      pb <= m_bpt;
      if (m_valid && m_ready) begin
        rx_data.push_back(m_data);
        rx_keep.push_back(m_keep);
        rx_last.push_back(m_last);
        rx_bpt.push_back(m_bpt);
        rx_cyc.push_back(cyc);
      end
    end
  end

  function automatic logic [31:0] conv(input int v, input int e, output bit s);
    int w, hi, lo;
    s = 0;
    w = 8 * e;
    if (w >= 24) return 32'(v);
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (v > hi) begin s = 1; return 32'(hi); end
    if (v < lo) begin s = 1; return 32'(lo); end
    return 32'(v);
  endfunction

  task automatic model_packet(input int n, input int e);
    logic [127:0] w;
    logic [31:0]  c;
    bit           s;
    int           fill, bpw, nb;
    bpw  = 16 / (4 * e);
    w    = '0;
    fill = 0;
    for (int b = 0; b < n; b++) begin
      for (int i = 0; i < 4; i++) begin
        c = conv(vals[b][i], e, s);
        if (s) exp_sat++;
        for (int k = 0; k < e; k++) w[8*(fill*4*e + i*e + k) +: 8] = c[8*k +: 8];
      end
      fill++;
      if (fill == bpw || b == n - 1) begin
        nb = fill * 4 * e;
        exp_data.push_back(w);
        exp_keep.push_back(16'((32'h1 << nb) - 1));
        exp_last.push_back(b == n - 1);
        exp_bpt.push_back(8'(nb));
        w    = '0;
        fill = 0;
      end
    end
  endtask

  task automatic send_beat(input int b, input logic [2:0] eb, input logic last);
    int t;
    s_valid      = 1'b1;
    s_last       = last;
    s_elem_bytes = eb;
    for (int i = 0; i < 4; i++) s_data[24*i +: 24] = 24'(vals[b][i]);
    t = 0;
    @(negedge clk);
    while (!s_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      tests++;
      failed++;
      $display("FAIL send_beat_timeout beat %0d: s_ready stayed 0, required 1", b);
    end
    @(posedge clk);
    #1;
    acc_cyc.push_back(cyc);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_packet(input int n, input logic [2:0] eb);
    for (int b = 0; b < n; b++) begin
      send_beat(b, (b == 0) ? eb : 3'($urandom_range(0, 7)), b == n - 1);
      if (gap_en && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_words(input int n, output bit ok);
    int t = 0;
    while (rx_data.size() < n && t < 4000) begin
      @(negedge clk);
      t++;
    end
    ok = (rx_data.size() >= n);
  endtask

  task automatic do_reset();
    areset  = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    areset = 1'b0;
    rx_data.delete(); rx_keep.delete(); rx_last.delete(); rx_bpt.delete(); rx_cyc.delete();
    acc_cyc.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    areset = 1'b0;
    @(negedge clk);
    tests += 8;
    if (m_valid !== 1'b0) begin failed++; $display("FAIL rst_m_valid got %b exp 0", m_valid); end
    if (m_last !== 1'b0) begin failed++; $display("FAIL rst_m_last got %b exp 0", m_last); end
    if (m_data !== '0) begin failed++; $display("FAIL rst_m_data got %h exp 0", m_data); end
    if (m_keep !== '0) begin failed++; $display("FAIL rst_m_keep got %h exp 0", m_keep); end
    if (m_bpt !== '0) begin failed++; $display("FAIL rst_bpt got %0d exp 0", m_bpt); end
    if (sat_count !== '0) begin failed++; $display("FAIL rst_sat got %0d exp 0", sat_count); end
    if (cfg_err !== 1'b0) begin failed++; $display("FAIL rst_cfg_err got %b exp 0", cfg_err); end
    if (s_ready !== 1'b1) begin failed++; $display("FAIL rst_s_ready got %b exp 1", s_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_e4();
    logic [127:0] ed[3];
    bit ok;
    do_reset();
    ed[0] = {32'h0000_0003, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFB};
    ed[1] = {32'hFF80_0000, 32'h007F_FFFF, 32'hFFFF_FFFF, 32'h0000_0064};
    ed[2] = {32'h0000_000A, 32'h0000_0009, 32'h0000_0008, 32'h0000_0007};
    vals[0] = '{-5, 1, 2, 3};
    vals[1] = '{100, -1, 8388607, -8388608};
    vals[2] = '{7, 8, 9, 10};
    send_beat(0, 3'd4, 1'b0);
    send_beat(1, 3'd0, 1'b0);
    send_beat(2, 3'd7, 1'b1);
    wait_words(3, ok);
    tests++;
    if (!ok) begin failed++; $display("FAIL e4_count got %0d exp 3", rx_data.size()); end
    tests++;
    if (acc_cyc[2] - acc_cyc[0] != 2) begin
      failed++; $display("FAIL e4_accept_rate got %0d exp 2", acc_cyc[2] - acc_cyc[0]);
    end
    for (int k = 0; k < 3; k++) begin
      tests += 5;
      if (rx_data[k] !== ed[k]) begin
        failed++; $display("FAIL e4_data[%0d] got %h exp %h", k, rx_data[k], ed[k]);
      end
      if (rx_keep[k] !== 16'hFFFF) begin
        failed++; $display("FAIL e4_keep[%0d] got %h exp ffff", k, rx_keep[k]);
      end
      if (rx_bpt[k] !== 8'd16) begin
        failed++; $display("FAIL e4_bpt[%0d] got %0d exp 16", k, rx_bpt[k]);
      end
      if (rx_last[k] !== (k == 2)) begin
        failed++; $display("FAIL e4_last[%0d] got %b exp %b", k, rx_last[k], k == 2);
      end
      if (rx_cyc[k] != acc_cyc[k]) begin
        failed++; $display("FAIL e4_latency[%0d] got cycle %0d exp %0d", k, rx_cyc[k], acc_cyc[k]);
      end
    end
  endtask

  task automatic test_e1_full();
    bit ok;
    do_reset();
    for (int b = 0; b < 4; b++) for (int i = 0; i < 4; i++) vals[b][i] = 4 * b + i;
    for (int b = 0; b < 4; b++) send_beat(b, (b == 0) ? 3'd1 : 3'd4, b == 3);
    wait_words(1, ok);
    repeat (4) @(negedge clk);
    tests += 5;
    if (rx_data.size() != 1) begin
      failed++; $display("FAIL e1full_count got %0d exp 1", rx_data.size());
    end
    if (rx_data[0] !== 128'h0F0E0D0C_0B0A0908_07060504_03020100) begin
      failed++; $display("FAIL e1full_data got %h exp 0f0e..0100", rx_data[0]);
    end
    if (rx_keep[0] !== 16'hFFFF) begin
      failed++; $display("FAIL e1full_keep got %h exp ffff", rx_keep[0]);
    end
    if (rx_bpt[0] !== 8'd16) begin failed++; $display("FAIL e1full_bpt got %0d exp 16", rx_bpt[0]); end
    if (rx_last[0] !== 1'b1) begin failed++; $display("FAIL e1full_last got %b exp 1", rx_last[0]); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_e1_partial();
    bit ok;
    do_reset();
    for (int b = 0; b < 6; b++) for (int i = 0; i < 4; i++) vals[b][i] = 16 + 4 * b + i;
    for (int b = 0; b < 6; b++) send_beat(b, (b == 0) ? 3'd1 : 3'd2, b == 5);
    wait_words(2, ok);
    repeat (4) @(negedge clk);
    tests += 8;
    if (rx_data.size() != 2) begin
      failed++; $display("FAIL e1part_count got %0d exp 2", rx_data.size());
    end
    if (rx_data[0] !== 128'h1F1E1D1C_1B1A1918_17161514_13121110) begin
      failed++; $display("FAIL e1part_data0 got %h exp 1f1e..1110", rx_data[0]);
    end
    if (rx_keep[0] !== 16'hFFFF) begin
      failed++; $display("FAIL e1part_keep0 got %h exp ffff", rx_keep[0]);
    end
    if (rx_last[0] !== 1'b0) begin failed++; $display("FAIL e1part_last0 got %b exp 0", rx_last[0]); end
    if (rx_data[1] !== 128'h00000000_00000000_27262524_23222120) begin
      failed++; $display("FAIL e1part_data1 got %h exp 0..27262524_23222120", rx_data[1]);
    end
    if (rx_keep[1] !== 16'h00FF) begin
      failed++; $display("FAIL e1part_keep1 got %h exp 00ff", rx_keep[1]);
    end
    if (rx_bpt[1] !== 8'd8) begin failed++; $display("FAIL e1part_bpt1 got %0d exp 8", rx_bpt[1]); end
    if (rx_last[1] !== 1'b1) begin failed++; $display("FAIL e1part_last1 got %b exp 1", rx_last[1]); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_e2_sat();
    bit ok;
    do_reset();
    vals[0] = '{40000, -40000, 1234, -1};
    send_beat(0, 3'd2, 1'b1);
    wait_words(1, ok);
    tests += 6;
    if (!ok) begin failed++; $display("FAIL e2_count got %0d exp 1", rx_data.size()); end
    if (rx_data[0] !== 128'h00000000_00000000_FFFF04D2_80007FFF) begin
      failed++; $display("FAIL e2_data got %h exp ..ffff04d2_80007fff", rx_data[0]);
    end
    if (rx_keep[0] !== 16'h00FF) begin failed++; $display("FAIL e2_keep got %h exp 00ff", rx_keep[0]); end
    if (rx_bpt[0] !== 8'd8) begin failed++; $display("FAIL e2_bpt got %0d exp 8", rx_bpt[0]); end
    if (sat_count !== 16'd2) begin failed++; $display("FAIL e2_sat got %0d exp 2", sat_count); end
    if (cfg_err !== 1'b0) begin failed++; $display("FAIL e2_cfg_err got %b exp 0", cfg_err); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    bit ok;
    int e, n, st0, r;
    do_reset();
    exp_data.delete(); exp_keep.delete(); exp_last.delete(); exp_bpt.delete();
    exp_sat = 0;
    st0     = stall_err;
    bp_en   = 1;
    gap_en  = 1;
    for (int p = 0; p < 100; p++) begin
      r = $urandom_range(0, 2);
      e = (r == 0) ? 1 : (r == 1) ? 2 : 4;
      n = $urandom_range(1, 6);
      for (int b = 0; b < n; b++) begin
        for (int i = 0; i < 4; i++) begin
          if ($urandom_range(0, 1) == 1) vals[b][i] = (int'($urandom) <<< 8) >>> 8;
          else vals[b][i] = int'($urandom_range(0, 400)) - 200;
        end
      end
      model_packet(n, e);
      send_packet(n, 3'(e));
    end
    wait_words(exp_data.size(), ok);
    bp_en  = 0;
    gap_en = 0;
    @(posedge clk);
    #2;
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    tests += 3;
    if (rx_data.size() != exp_data.size()) begin
      failed++; $display("FAIL rand_count got %0d exp %0d", rx_data.size(), exp_data.size());
    end
    if (sat_count !== 16'((exp_sat > 65535) ? 65535 : exp_sat)) begin
      failed++; $display("FAIL rand_sat got %0d exp %0d", sat_count, exp_sat);
    end
    if (stall_err != st0) begin
      failed++; $display("FAIL rand_stall_stable got %0d changes exp 0", stall_err - st0);
    end
    for (int k = 0; k < exp_data.size() && k < rx_data.size(); k++) begin
      tests++;
      if (rx_data[k] !== exp_data[k] || rx_keep[k] !== exp_keep[k] ||
          rx_last[k] !== exp_last[k] || rx_bpt[k] !== exp_bpt[k]) begin
        failed++;
        $display("FAIL rand_word[%0d] got %h/%h/%b/%0d exp %h/%h/%b/%0d", k, rx_data[k],
                 rx_keep[k], rx_last[k], rx_bpt[k], exp_data[k], exp_keep[k], exp_last[k],
                 exp_bpt[k]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_cfg_err();
    bit ok;
    do_reset();
    vals[0] = '{-5, 6, 7, 8};
    send_beat(0, 3'd3, 1'b1);
    wait_words(1, ok);
    tests += 4;
    if (!ok) begin failed++; $display("FAIL cfg_count got %0d exp 1", rx_data.size()); end
    if (rx_data[0] !== {32'h8, 32'h7, 32'h6, 32'hFFFF_FFFB}) begin
      failed++; $display("FAIL cfg_data got %h exp 8_7_6_fffffffb", rx_data[0]);
    end
    if (rx_keep[0] !== 16'hFFFF) begin failed++; $display("FAIL cfg_keep got %h exp ffff", rx_keep[0]); end
    if (cfg_err !== 1'b1) begin failed++; $display("FAIL cfg_err got %b exp 1", cfg_err); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    // Stall a finished word, then reset: it must be dropped.
    m_ready = 1'b0;
    vals[0] = '{1, 2, 3, 4};
    send_beat(0, 3'd4, 1'b1);
    @(negedge clk);
    tests++;
    if (m_valid !== 1'b1) begin failed++; $display("FAIL mid_stalled_valid got %b exp 1", m_valid); end
    @(posedge clk);
    #1;
    areset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    areset = 1'b0;
    @(negedge clk);
    tests += 7;
    if (m_valid !== 1'b0) begin failed++; $display("FAIL mid_m_valid got %b exp 0", m_valid); end
    if (m_data !== '0) begin failed++; $display("FAIL mid_m_data got %h exp 0", m_data); end
    if (m_keep !== '0) begin failed++; $display("FAIL mid_m_keep got %h exp 0", m_keep); end
    if (m_last !== 1'b0) begin failed++; $display("FAIL mid_m_last got %b exp 0", m_last); end
    if (m_bpt !== '0) begin failed++; $display("FAIL mid_bpt got %0d exp 0", m_bpt); end
    if (sat_count !== '0) begin failed++; $display("FAIL mid_sat got %0d exp 0", sat_count); end
    if (cfg_err !== 1'b0) begin failed++; $display("FAIL mid_cfg_err got %b exp 0", cfg_err); end
    @(posedge clk);
    #1;
    rx_data.delete(); rx_keep.delete(); rx_last.delete(); rx_bpt.delete(); rx_cyc.delete();
    // Leave a partial accumulator of 0xFF bytes, reset, then send a fresh packet.
    m_ready = 1'b1;
    vals[1] = '{-1, -1, -1, -1};
    send_beat(1, 3'd1, 1'b0);
    areset = 1'b1;
    @(posedge clk);
    #1;
    areset = 1'b0;
    vals[2] = '{1, 2, 3, 4};
    send_beat(2, 3'd1, 1'b1);
    wait_words(1, ok);
    repeat (4) @(negedge clk);
    tests += 5;
    if (rx_data.size() != 1) begin
      failed++; $display("FAIL mid_count got %0d exp 1", rx_data.size());
    end
    if (rx_data[0] !== 128'h0000_0000_0000_0000_0000_0000_0403_0201) begin
      failed++; $display("FAIL mid_data got %h exp ..04030201", rx_data[0]);
    end
    if (rx_keep[0] !== 16'h000F) begin failed++; $display("FAIL mid_keep got %h exp 000f", rx_keep[0]); end
    if (rx_bpt[0] !== 8'd4) begin failed++; $display("FAIL mid_bpt_new got %0d exp 4", rx_bpt[0]); end
    if (rx_last[0] !== 1'b1) begin failed++; $display("FAIL mid_last_new got %b exp 1", rx_last[0]); end
  endtask

  initial begin
    areset       = 1'b1;
    s_valid      = 1'b0;
    s_last       = 1'b0;
    s_data       = '0;
    s_elem_bytes = 3'd4;
    m_ready      = 1'b1;
    test_reset();
    test_e4();
    test_e1_full();
    test_e1_partial();
    test_e2_sat();
    test_random();
    test_cfg_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/axis_out_packer.md
Name: axis_out_packer

Overview:
Runtime-configurable output packer that sits between the output shifter and the AXI-Stream master port of the DNN engine. Each input beat carries ROWS signed Y_BITS results. The block narrows each result (saturating) or sign-extends it to a per-packet element size of 1, 2 or 4 bytes. It packs whole input beats little-endian into M_WIDTH-bit output words, with tkeep, tlast and a bytes-per-transfer sideband. It generalises the fixed sign-padding width adapter to selectable element widths with saturation and partial-word flush.

Parameters:
ROWS, 4, elements per input beat
Y_BITS, 24, signed bits per input element (2..32)
M_WIDTH, 128, output data width in bits; M_WIDTH/8 must be a multiple of ROWS*4
W_BPT, 8, width of bytes-per-transfer sideband; must hold M_WIDTH/8

Ports:
aclk  in  1  clock
areset  in  1  synchronous active-high reset
s_valid  in  1  input beat valid
s_ready  out  1  input beat accepted when s_valid&s_ready
s_data  in  ROWS*Y_BITS  element i at bits [Y_BITS*(i+1)-1 : Y_BITS*i]
s_last  in  1  last beat of packet
s_elem_bytes  in  3  element size 1/2/4; sampled on the first beat of each packet
m_valid  out  1  output word valid
m_ready  in  1  downstream ready
m_data  out  M_WIDTH  packed output
m_keep  out  M_WIDTH/8  byte enables
m_last  out  1  last word of packet
m_bytes_per_transfer  out  W_BPT  count of ones in m_keep
sat_count  out  16  saturating count of clamped elements since reset
cfg_err  out  1  sticky: illegal s_elem_bytes seen

Behaviour:
- Single clock domain; all state resets synchronously on areset.
- After reset: m_valid=0, m_last=0, m_data=0, m_keep=0, m_bytes_per_transfer=0, sat_count=0, cfg_err=0; fill count=0; state IDLE.
- Handshake: s_ready = !m_valid | m_ready (combinational).
  - m_data, m_keep, m_last and m_bytes_per_transfer hold stable while m_valid & !m_ready.
  - Sustains 1 input beat per cycle.
- Element conversion, with E = element bytes and W = 8E:
  - If W >= Y_BITS: sign-extend.
  - Else clamp to [-2^(W-1), 2^(W-1)-1].
  - Each clamped element increments sat_count, which saturates at 0xFFFF.
- Packing:
  - BPW = (M_WIDTH/8)/(ROWS*E) input beats per output word.
  - Beat k of a word occupies bytes [k*ROWS*E, (k+1)*ROWS*E); element i within a beat is at byte offset i*E.
- States:
  - IDLE: on the first accepted beat, latch E from s_elem_bytes and go to PACK. Values other than 1/2/4 set cfg_err and use E=4.
  - PACK: accept beats into the accumulator; fill count increments.
- Word emit:
  - A word is emitted on the accepted beat that makes fill = BPW, or on an accepted beat with s_last.
  - On emit, in the same cycle: the accumulator plus the current beat load into the output register, m_valid=1 next cycle, and fill resets to 0.
  - s_last additionally sets m_last and returns to IDLE.
- Latency: the emitting input beat appears on m_* on the next cycle.
- Partial flush: m_keep covers only the filled bytes (fill*ROWS*E ones, LSB-aligned). Unfilled data bytes are 0.
- m_bytes_per_transfer equals popcount(m_keep).
- A 1-beat packet is legal; m_last is set on its single word.
- Simultaneous events:
  - An output-register hand-off (m_ready) and a new emit in the same cycle: the new word replaces the old one with no bubble.
  - An accept while m_valid & !m_ready cannot occur because s_ready=0.
- s_elem_bytes is ignored on non-first beats; the element size is constant within a packet.
- areset mid-packet: partial accumulator is discarded and the output word is dropped. No m_last is generated.

Decomposition:
- Shared package: element-size encodings (EB_1=1, EB_2=2, EB_4=4), state enum {IDLE, PACK}, helper constant M_BYTES=M_WIDTH/8.
- One sub-module, out_elem_convert, is natural. It is combinational; inputs are ROWS x Y_BITS and E, outputs are ROWS x 32-bit converted lanes plus a per-lane sat flag.
- Packing, keep generation and the output register stay in axis_out_packer.

Test Plan:
- E=4, 3-beat packet, m_ready=1 -> 3 words, each with m_keep=0xFFFF and m_bytes_per_transfer=16. Element value -5 appears as 0xFFFFFFFB. m_last is set on word 3. One word per cycle after 1-cycle latency.
- E=1, 4 beats of values 0..15 -> single word with bytes 0x00..0x0F, m_keep=0xFFFF, m_last=1.
- E=1, 6-beat packet -> word1 full, word2 m_keep=0x00FF, m_bytes_per_transfer=8, upper data bytes 0, m_last=1.
- E=2, inputs 40000 and -40000 -> 0x7FFF and 0x8000; sat_count increments by 2; unclamped 1234 passes as 0x04D2.
- Random m_ready backpressure (50%) over 100 packets with random E -> output matches the reference model byte-for-byte; data stays stable while stalled; no beat loss.
- s_elem_bytes=3 -> cfg_err=1 and the packet is packed as E=4. areset asserted mid-packet, then a new packet -> no stale bytes and all outputs return to reset values.
